// File: rtl/pi_bus_pkg.sv
// Shared definitions for the PI bus master: FSM state type, block-select
// indices, bus widths and a one-hot decode helper.
package pi_bus_pkg;

   localparam int DATA_W  = 8;
   localparam int ADDR_W  = 8;
   localparam int BLK_W   = 4;
   localparam int NUM_BLK = 16;
   localparam int IRQ_W   = 3;

   // Block indices of the populated peripherals
   localparam logic [BLK_W-1:0] DISP_BLK  = 4'd0;
   localparam logic [BLK_W-1:0] DDR2_MGR  = 4'd1;
   localparam logic [BLK_W-1:0] FRAC_UNIT = 4'd2;
   localparam logic [BLK_W-1:0] MOUSE     = 4'd3;
   localparam logic [BLK_W-1:0] ALU       = 4'd4;
   localparam logic [BLK_W-1:0] UART      = 4'd5;
   localparam logic [BLK_W-1:0] CPU       = 4'd6;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_WAIT   = 2'd2,
      ST_RESP   = 2'd3
   } pi_state_e;

   // One-hot decode of a block index onto the block-select vector
   function automatic logic [NUM_BLK-1:0] blk_onehot(input logic [BLK_W-1:0] blk);
      logic [NUM_BLK-1:0] sel;
      sel = '0;
      sel[blk] = 1'b1;
      return sel;
   endfunction

endpackage

// File: rtl/pi_irq_collect.sv
// Interrupt collector: latches irq_in bits until individually cleared.
// A set and a clear on the same bit in the same cycle leaves the bit set.
// interrupt_ack pulses the cycle after any clear bit is seen.
module pi_irq_collect
   import pi_bus_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IRQ_W-1:0] irq_in,
   input  logic [IRQ_W-1:0] irq_clr,
   output logic [IRQ_W-1:0] irq_pending,
   output logic             interrupt_ack
);

   logic [IRQ_W-1:0] pending_q, pending_d;
   logic             ack_q, ack_d;

   // Next pending state: clear first, then set so set wins
   always_comb begin
      pending_d = (pending_q & ~irq_clr) | irq_in;
      ack_d     = |irq_clr;
   end

   // Pending/ack registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q <= '0;
         ack_q     <= 1'b0;
      end else begin
         pending_q <= pending_d;
         ack_q     <= ack_d;
      end
   end

   assign irq_pending   = pending_q;
   assign interrupt_ack = ack_q;

endmodule

// File: rtl/pi_bus_master.sv
// PI bus master: turns single host requests into one-cycle PI bus write or
// read strobes and returns a one-cycle response. Requests to blocks absent
// from BLK_MASK are answered immediately with an error and never reach the bus.
// Optional interrupt collection is enabled with the PI_IRQ_COLLECT_EN macro.
module pi_bus_master
   import pi_bus_pkg::*;
#(
   parameter int                 RD_LATENCY = 1,
   parameter logic [NUM_BLK-1:0] BLK_MASK   = 16'h007F
)
(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_wr,
   input  logic [BLK_W-1:0]          req_blk,
   input  logic [ADDR_W-1:0]         req_addr,
   input  logic [DATA_W-1:0]         req_wdata,
   output logic                      rsp_valid,
   output logic [DATA_W-1:0]         rsp_rdata,
   output logic                      rsp_err,
   output logic [NUM_BLK-1:0]        pi_blk_sel,
   output logic [ADDR_W-1:0]         pi_addr,
   output logic                      pi_wr_en,
   output logic                      pi_rd_en,
   output logic [DATA_W-1:0]         pi_wr_data,
   input  logic [NUM_BLK*DATA_W-1:0] pi_rd_data_bus
`ifdef PI_IRQ_COLLECT_EN
   ,
   input  logic [IRQ_W-1:0]          irq_in,
   input  logic [IRQ_W-1:0]          irq_clr,
   output logic [IRQ_W-1:0]          irq_pending,
   output logic                      interrupt_ack
`endif
);

   // WAIT covers RD_LATENCY-1 cycles; the counter is loaded with the number
   // of WAIT cycles remaining after the first one.
   localparam logic [1:0] WAIT_INIT = (RD_LATENCY > 1) ? 2'(RD_LATENCY - 2) : 2'd0;

   pi_state_e           state_q, state_d;
   logic [1:0]          wait_cnt_q, wait_cnt_d;
   logic                wr_q, wr_d;
   logic [BLK_W-1:0]    blk_q, blk_d;

   logic                req_ready_q, req_ready_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                rsp_err_q, rsp_err_d;
   logic [NUM_BLK-1:0]  pi_blk_sel_q, pi_blk_sel_d;
   logic [ADDR_W-1:0]   pi_addr_q, pi_addr_d;
   logic                pi_wr_en_q, pi_wr_en_d;
   logic                pi_rd_en_q, pi_rd_en_d;
   logic [DATA_W-1:0]   pi_wr_data_q, pi_wr_data_d;

   logic [DATA_W-1:0]   rd_byte;

   // Byte lane of the block currently being read
   assign rd_byte = pi_rd_data_bus[{blk_q, 3'b000} +: DATA_W];

   // Next-state and next-output logic; every output register is computed
   // from the transition so that strobes line up with the new state
   always_comb begin
      state_d      = state_q;
      wait_cnt_d   = wait_cnt_q;
      wr_d         = wr_q;
      blk_d        = blk_q;
      rsp_valid_d  = 1'b0;
      rsp_rdata_d  = '0;
      rsp_err_d    = 1'b0;
      pi_blk_sel_d = '0;
      pi_addr_d    = '0;
      pi_wr_en_d   = 1'b0;
      pi_rd_en_d   = 1'b0;
      pi_wr_data_d = '0;

      case (state_q)
         ST_IDLE: begin
            if (req_valid && req_ready_q) begin
               wr_d  = req_wr;
               blk_d = req_blk;
               if (!BLK_MASK[req_blk]) begin
                  // Unpopulated block: answer with an error, bus untouched
                  state_d     = ST_RESP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
               end else begin
                  state_d      = ST_ACCESS;
                  pi_blk_sel_d = blk_onehot(req_blk);
                  pi_addr_d    = req_addr;
                  if (req_wr) begin
                     pi_wr_en_d   = 1'b1;
                     pi_wr_data_d = req_wdata;
                  end else begin
                     pi_rd_en_d   = 1'b1;
                  end
               end
            end
         end

         ST_ACCESS: begin
            if (wr_q) begin
               state_d     = ST_RESP;
               rsp_valid_d = 1'b1;
            end else if (RD_LATENCY <= 1) begin
               // Data is valid one edge after the strobe: sample now
               state_d     = ST_RESP;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = rd_byte;
            end else begin
               state_d      = ST_WAIT;
               wait_cnt_d   = WAIT_INIT;
               pi_blk_sel_d = pi_blk_sel_q;
               pi_addr_d    = pi_addr_q;
            end
         end

         ST_WAIT: begin
            if (wait_cnt_q == 2'd0) begin
               state_d     = ST_RESP;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = rd_byte;
            end else begin
               wait_cnt_d   = wait_cnt_q - 2'd1;
               pi_blk_sel_d = pi_blk_sel_q;
               pi_addr_d    = pi_addr_q;
            end
         end

         ST_RESP: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      req_ready_d = (state_d == ST_IDLE);
   end

   // State and output registers; reset clears everything including ready
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         wait_cnt_q   <= 2'd0;
         wr_q         <= 1'b0;
         blk_q        <= '0;
         req_ready_q  <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_rdata_q  <= '0;
         rsp_err_q    <= 1'b0;
         pi_blk_sel_q <= '0;
         pi_addr_q    <= '0;
         pi_wr_en_q   <= 1'b0;
         pi_rd_en_q   <= 1'b0;
         pi_wr_data_q <= '0;
      end else begin
         state_q      <= state_d;
         wait_cnt_q   <= wait_cnt_d;
         wr_q         <= wr_d;
         blk_q        <= blk_d;
         req_ready_q  <= req_ready_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_rdata_q  <= rsp_rdata_d;
         rsp_err_q    <= rsp_err_d;
         pi_blk_sel_q <= pi_blk_sel_d;
         pi_addr_q    <= pi_addr_d;
         pi_wr_en_q   <= pi_wr_en_d;
         pi_rd_en_q   <= pi_rd_en_d;
         pi_wr_data_q <= pi_wr_data_d;
      end
   end

   assign req_ready  = req_ready_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_rdata  = rsp_rdata_q;
   assign rsp_err    = rsp_err_q;
   assign pi_blk_sel = pi_blk_sel_q;
   assign pi_addr    = pi_addr_q;
   assign pi_wr_en   = pi_wr_en_q;
   assign pi_rd_en   = pi_rd_en_q;
   assign pi_wr_data = pi_wr_data_q;

`ifdef PI_IRQ_COLLECT_EN
   pi_irq_collect u_irq (
      .clk           (clk),
      .rst_n         (rst_n),
      .irq_in        (irq_in),
      .irq_clr       (irq_clr),
      .irq_pending   (irq_pending),
      .interrupt_ack (interrupt_ack)
   );
`endif

endmodule

// File: tb/tb_pi_bus_master.sv
// Directed testbench for pi_bus_master (RD_LATENCY=3, default block mask).
// Interrupt checks are compiled in when PI_IRQ_COLLECT_EN is defined.
module tb_pi_bus_master;
   import pi_bus_pkg::*;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid, req_ready, req_wr;
   logic [3:0]    req_blk;
   logic [7:0]    req_addr, req_wdata;
   logic          rsp_valid, rsp_err;
   logic [7:0]    rsp_rdata;
   logic [15:0]   pi_blk_sel;
   logic [7:0]    pi_addr, pi_wr_data;
   logic          pi_wr_en, pi_rd_en;
   logic [127:0]  pi_rd_data_bus;
`ifdef PI_IRQ_COLLECT_EN
   logic [2:0]    irq_in, irq_clr, irq_pending;
   logic          interrupt_ack;
`endif

   int errors = 0;
   int checks = 0;

   // Per-cycle capture of one transaction (index = cycles after accept)
   logic          c_wr[0:15], c_rd[0:15], c_rv[0:15], c_err[0:15], c_rdy[0:15];
   logic [15:0]   c_sel[0:15];
   logic [7:0]    c_addr[0:15], c_wd[0:15], c_rdata[0:15];

   always #5 clk = ~clk;

   pi_bus_master #(.RD_LATENCY(3), .BLK_MASK(16'h007F)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_wr         (req_wr),
      .req_blk        (req_blk),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .rsp_valid      (rsp_valid),
      .rsp_rdata      (rsp_rdata),
      .rsp_err        (rsp_err),
      .pi_blk_sel     (pi_blk_sel),
      .pi_addr        (pi_addr),
      .pi_wr_en       (pi_wr_en),
      .pi_rd_en       (pi_rd_en),
      .pi_wr_data     (pi_wr_data),
      .pi_rd_data_bus (pi_rd_data_bus)
`ifdef PI_IRQ_COLLECT_EN
      ,
      .irq_in         (irq_in),
      .irq_clr        (irq_clr),
      .irq_pending    (irq_pending),
      .interrupt_ack  (interrupt_ack)
`endif
   );

   // Read-data bus for cycle k: block i shows 8'h80+i, block 2 shows 8'h5C
   // only during cycle 3 so a sample on the wrong edge returns 8'hEE
   function automatic logic [127:0] bus_for(input int k);
      logic [127:0] b;
      for (int i = 0; i < 16; i++) b[i*8 +: 8] = 8'h80 + 8'(i);
      b[2*8 +: 8] = (k == 3) ? 8'h5C : 8'hEE;
      return b;
   endfunction

   // Issue one request once ready, then capture ncyc cycles of outputs
   task automatic run_req(input logic wr, input logic [3:0] blk,
                          input logic [7:0] addr, input logic [7:0] wdata,
                          input int ncyc);
      int guard = 0;
      @(negedge clk);
      while (!req_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_timeout: req_ready=%b expected 1 within 20 cycles", req_ready);
      end
      $display("txn wr=%0d blk=%0d addr=%h wdata=%h", wr, blk, addr, wdata);
      req_valid = 1'b1; req_wr = wr; req_blk = blk; req_addr = addr; req_wdata = wdata;
      pi_rd_data_bus = bus_for(0);
      for (int k = 1; k <= ncyc; k++) begin
         @(negedge clk);
         if (k == 1) req_valid = 1'b0;
         c_wr[k] = pi_wr_en;   c_rd[k] = pi_rd_en;   c_rv[k] = rsp_valid;
         c_err[k] = rsp_err;   c_rdy[k] = req_ready; c_sel[k] = pi_blk_sel;
         c_addr[k] = pi_addr;  c_wd[k] = pi_wr_data; c_rdata[k] = rsp_rdata;
         pi_rd_data_bus = bus_for(k);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", req_ready); end
      checks++;
      if ({pi_blk_sel, pi_addr, pi_wr_data, pi_wr_en, pi_rd_en} !== 34'd0) begin
         errors++; $display("FAIL reset_pi: got sel=%h addr=%h wd=%h wr=%b rd=%b expected all 0",
                             pi_blk_sel, pi_addr, pi_wr_data, pi_wr_en, pi_rd_en);
      end
      checks++;
      if ({rsp_valid, rsp_err, rsp_rdata} !== 10'd0) begin
         errors++; $display("FAIL reset_rsp: got v=%b e=%b d=%h expected 0", rsp_valid, rsp_err, rsp_rdata);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", req_ready); end
      $display("txn reset done");
   endtask

   task automatic test_write();
      int nwr = 0, nrsp = 0, nrd = 0;
      run_req(1'b1, ALU, 8'h03, 8'hA5, 6);
      for (int k = 1; k <= 6; k++) begin
         nwr += int'(c_wr[k]); nrsp += int'(c_rv[k]); nrd += int'(c_rd[k]);
      end
      checks++;
      if (c_wr[1] !== 1'b1 || nwr != 1) begin errors++; $display("FAIL wr_strobe: wr_en@1=%b count=%0d expected 1 and 1", c_wr[1], nwr); end
      checks++;
      if (c_sel[1] !== 16'h0010) begin errors++; $display("FAIL wr_blk_sel: got %h expected 0010", c_sel[1]); end
      checks++;
      if (c_addr[1] !== 8'h03 || c_wd[1] !== 8'hA5) begin errors++; $display("FAIL wr_addr_data: got %h/%h expected 03/a5", c_addr[1], c_wd[1]); end
      checks++;
      if (c_rv[2] !== 1'b1 || nrsp != 1) begin errors++; $display("FAIL wr_rsp_timing: rsp@2=%b count=%0d expected 1 and 1", c_rv[2], nrsp); end
      checks++;
      if (c_err[2] !== 1'b0 || c_rdata[2] !== 8'h00) begin errors++; $display("FAIL wr_rsp_fields: err=%b rdata=%h expected 0/00", c_err[2], c_rdata[2]); end
      checks++;
      if (c_sel[2] !== 16'h0 || c_addr[2] !== 8'h0 || c_wd[2] !== 8'h0 || nrd != 0) begin
         errors++; $display("FAIL wr_idle_outputs: sel=%h addr=%h wd=%h rd_count=%0d expected 0", c_sel[2], c_addr[2], c_wd[2], nrd);
      end
      checks++;
      if (c_rdy[1] !== 1'b0 || c_rdy[2] !== 1'b0 || c_rdy[3] !== 1'b1) begin
         errors++; $display("FAIL wr_ready: got %b%b%b expected 001", c_rdy[1], c_rdy[2], c_rdy[3]);
      end
   endtask

   task automatic test_read();
      int nrd = 0, nrsp = 0, nwr = 0;
      run_req(1'b0, FRAC_UNIT, 8'h10, 8'h00, 7);
      for (int k = 1; k <= 7; k++) begin
         nrd += int'(c_rd[k]); nrsp += int'(c_rv[k]); nwr += int'(c_wr[k]);
      end
      checks++;
      if (c_rd[1] !== 1'b1 || nrd != 1 || nwr != 0) begin errors++; $display("FAIL rd_strobe: rd_en@1=%b rd=%0d wr=%0d expected 1,1,0", c_rd[1], nrd, nwr); end
      checks++;
      if (c_sel[1] !== 16'h0004 || c_sel[2] !== 16'h0004 || c_sel[3] !== 16'h0004 || c_sel[4] !== 16'h0000) begin
         errors++; $display("FAIL rd_blk_sel_hold: got %h %h %h %h expected 0004 0004 0004 0000", c_sel[1], c_sel[2], c_sel[3], c_sel[4]);
      end
      checks++;
      if (c_addr[1] !== 8'h10 || c_addr[3] !== 8'h10) begin errors++; $display("FAIL rd_addr_hold: got %h %h expected 10 10", c_addr[1], c_addr[3]); end
      checks++;
      if (c_rv[4] !== 1'b1 || nrsp != 1) begin errors++; $display("FAIL rd_rsp_timing: rsp@4=%b count=%0d expected 1 and 1", c_rv[4], nrsp); end
      checks++;
      if (c_rdata[4] !== 8'h5C || c_err[4] !== 1'b0) begin errors++; $display("FAIL rd_data: got %h err=%b expected 5c err=0", c_rdata[4], c_err[4]); end
   endtask

   task automatic test_unpopulated();
      int nstb = 0, nrsp = 0;
      run_req(1'b0, 4'd9, 8'h44, 8'h00, 4);
      for (int k = 1; k <= 4; k++) begin
         nstb += int'(c_wr[k]) + int'(c_rd[k]) + int'(c_sel[k] != 16'h0);
         nrsp += int'(c_rv[k]);
      end
      checks++;
      if (nstb != 0) begin errors++; $display("FAIL err_no_strobe: got %0d bus activity cycles expected 0", nstb); end
      checks++;
      if (c_rv[1] !== 1'b1 || nrsp != 1) begin errors++; $display("FAIL err_rsp_timing: rsp@1=%b count=%0d expected 1 and 1", c_rv[1], nrsp); end
      checks++;
      if (c_err[1] !== 1'b1 || c_rdata[1] !== 8'h00) begin errors++; $display("FAIL err_rsp_fields: err=%b rdata=%h expected 1/00", c_err[1], c_rdata[1]); end
      checks++;
      if (c_err[3] !== 1'b0) begin errors++; $display("FAIL err_rsp_clears: err=%b expected 0", c_err[3]); end
   endtask

   task automatic test_back_to_back();
      int idx = 0, npulse = 0, nrsp = 0, rdy_bad = 0;
      logic pend = 1'b0;
      int pcyc[0:2];
      logic [7:0] paddr[0:2];
      logic [7:0] pdata[0:2];
      for (int i = 0; i < 3; i++) begin pcyc[i] = -1; paddr[i] = 8'h0; pdata[i] = 8'h0; end
      @(negedge clk);
      req_valid = 1'b1; req_wr = 1'b1; req_blk = UART; req_addr = 8'h20; req_wdata = 8'h30;
      for (int t = 0; t < 20; t++) begin
         if (t > 0) @(negedge clk);
         if (pi_wr_en) begin
            if (npulse < 3) begin pcyc[npulse] = t; paddr[npulse] = pi_addr; pdata[npulse] = pi_wr_data; end
            npulse++;
            if (req_ready) rdy_bad++;
         end
         if (rsp_valid) begin
            nrsp++;
            if (req_ready) rdy_bad++;
         end
         if (pend) begin
            idx++;
            if (idx < 3) begin
               req_addr = 8'h20 + 8'(idx); req_wdata = 8'h30 + 8'(idx);
            end else begin
               req_valid = 1'b0;
            end
         end
         pend = req_ready && req_valid;
      end
      req_valid = 1'b0;
      $display("txn back_to_back pulses=%0d responses=%0d", npulse, nrsp);
      checks++;
      if (npulse != 3 || nrsp != 3) begin errors++; $display("FAIL b2b_count: pulses=%0d rsp=%0d expected 3 and 3", npulse, nrsp); end
      checks++;
      if (pcyc[1] - pcyc[0] != 3 || pcyc[2] - pcyc[1] != 3) begin
         errors++; $display("FAIL b2b_spacing: cycles %0d %0d %0d expected spacing 3", pcyc[0], pcyc[1], pcyc[2]);
      end
      checks++;
      if (paddr[0] !== 8'h20 || paddr[1] !== 8'h21 || paddr[2] !== 8'h22 ||
          pdata[0] !== 8'h30 || pdata[1] !== 8'h31 || pdata[2] !== 8'h32) begin
         errors++; $display("FAIL b2b_order: addr %h %h %h data %h %h %h expected 20 21 22 / 30 31 32",
                             paddr[0], paddr[1], paddr[2], pdata[0], pdata[1], pdata[2]);
      end
      checks++;
      if (rdy_bad != 0) begin errors++; $display("FAIL b2b_ready_busy: ready high in %0d busy cycles expected 0", rdy_bad); end
   endtask

   task automatic test_reset_mid();
      int nrsp = 0;
      logic rdy_after;
      @(negedge clk);
      req_valid = 1'b1; req_wr = 1'b0; req_blk = FRAC_UNIT; req_addr = 8'h10;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      // Cycle 2 of a latency-3 read: FSM is in WAIT with block select held
      checks++;
      if (pi_blk_sel !== 16'h0004) begin errors++; $display("FAIL mid_pre_wait: sel=%h expected 0004", pi_blk_sel); end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({pi_blk_sel, pi_addr, pi_wr_data, pi_wr_en, pi_rd_en, rsp_valid, req_ready} !== 36'd0) begin
         errors++; $display("FAIL mid_async_clear: sel=%h addr=%h rd=%b rsp=%b rdy=%b expected 0",
                             pi_blk_sel, pi_addr, pi_rd_en, rsp_valid, req_ready);
      end
      for (int t = 0; t < 2; t++) begin
         @(negedge clk);
         nrsp += int'(rsp_valid);
      end
      rst_n = 1'b1;
      @(negedge clk);
      rdy_after = req_ready;
      nrsp += int'(rsp_valid);
      for (int t = 0; t < 5; t++) begin
         @(negedge clk);
         nrsp += int'(rsp_valid);
      end
      $display("txn reset_mid responses=%0d", nrsp);
      checks++;
      if (nrsp != 0) begin errors++; $display("FAIL mid_no_rsp: got %0d responses expected 0", nrsp); end
      checks++;
      if (rdy_after !== 1'b1) begin errors++; $display("FAIL mid_ready_after: got %b expected 1", rdy_after); end
   endtask

`ifdef PI_IRQ_COLLECT_EN
   task automatic test_irq();
      int nack = 0;
      @(negedge clk);
      irq_in = 3'b010;
      @(negedge clk);
      irq_in = 3'b000;
      checks++;
      if (irq_pending !== 3'b010) begin errors++; $display("FAIL irq_set: got %b expected 010", irq_pending); end
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (irq_pending !== 3'b010 || interrupt_ack !== 1'b0) begin
         errors++; $display("FAIL irq_hold: pending=%b ack=%b expected 010/0", irq_pending, interrupt_ack);
      end
      irq_clr = 3'b010;
      @(negedge clk);
      irq_clr = 3'b000;
      checks++;
      if (irq_pending !== 3'b000 || interrupt_ack !== 1'b1) begin
         errors++; $display("FAIL irq_clear: pending=%b ack=%b expected 000/1", irq_pending, interrupt_ack);
      end
      nack += int'(interrupt_ack);
      for (int t = 0; t < 3; t++) begin
         @(negedge clk);
         nack += int'(interrupt_ack);
      end
      checks++;
      if (nack != 1) begin errors++; $display("FAIL irq_ack_once: got %0d pulses expected 1", nack); end
      irq_in = 3'b100; irq_clr = 3'b100;
      @(negedge clk);
      irq_in = 3'b000; irq_clr = 3'b000;
      checks++;
      if (irq_pending !== 3'b100) begin errors++; $display("FAIL irq_set_wins: got %b expected 100", irq_pending); end
      $display("txn irq done");
   endtask
`endif

   initial begin
      req_valid = 1'b0; req_wr = 1'b0; req_blk = 4'd0; req_addr = 8'h0; req_wdata = 8'h0;
      pi_rd_data_bus = bus_for(0);
`ifdef PI_IRQ_COLLECT_EN
      irq_in = 3'b000; irq_clr = 3'b000;
`endif
      test_reset();
      test_write();
      test_read();
      test_unpopulated();
      test_back_to_back();
      test_reset_mid();
`ifdef PI_IRQ_COLLECT_EN
      test_irq();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
